vec_sum_seq: RTL and testbench

Sequencer that reduces a long signed integer vector by streaming it through one shared `vec_sum_int` adder tree, `length` elements per beat. It accumulates the per-beat tree sums over a runtime-selected number of chunks and presents one final sum per job over a valid/ready output. It sits between an element-streaming producer and any consumer of dot-product or block-sum results in the MX arithmetic path.

---
 rtl/vec_sum_seq.sv | 146 ++++++++++++++
 tb/tb_vec_sum_seq.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/vec_sum_seq.sv
// Chunked signed vector reducer: one shared adder tree, accumulated per job.
// Optional VEC_SUM_SEQ_SAT_EN saturates the narrowed result instead of wrapping.
module vec_sum_int #(
  parameter int bit_width  = 16,
  parameter int length     = 32,
  parameter int tree_width = bit_width + $clog2(length)
) (
  input  logic [bit_width*length-1:0] i_vec,
  output logic [tree_width-1:0]       o_sum
);

  always_comb begin
    o_sum = '0;
    for (int k = 0; k < length; k++) begin
      o_sum = o_sum
        + tree_width'($signed(i_vec[k*bit_width +: bit_width]));
    end
  end

endmodule

module vec_sum_seq #(
  parameter int bit_width  = 16,
  parameter int length     = 32,
  parameter int max_chunks = 64,
  parameter int tree_width = bit_width + $clog2(length),
  parameter int acc_width  = tree_width + $clog2(max_chunks),
  parameter int out_width  = acc_width
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [bit_width*length-1:0]   i_vec,
  input  logic [$clog2(max_chunks):0]   i_num_chunks,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic [out_width-1:0]          o_sum,
  output logic                          o_valid,
  input  logic                          i_ready,
  output logic                          o_busy
);

  localparam int CW = $clog2(max_chunks) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t                       state_q, state_d;
  logic signed [acc_width-1:0]  acc_q, acc_d;
  logic [CW-1:0]                cnt_q, cnt_d;
  logic [CW-1:0]                n_q, n_d;

  logic signed [tree_width-1:0] tree_sum;
  logic signed [acc_width-1:0]  tree_ext;
  logic [CW-1:0]                n_clamp;
  logic                         accept;

  vec_sum_int #(
    .bit_width (bit_width),
    .length    (length),
    .tree_width(tree_width)
  ) u_tree (
    .i_vec(i_vec),
    .o_sum(tree_sum)
  );

  assign tree_ext = acc_width'(tree_sum);

  assign o_ready = (state_q == IDLE) || (state_q == ACCUM);
  assign o_valid = (state_q == HOLD);
  assign o_busy  = (state_q != IDLE);
  assign accept  = i_valid && o_ready;

  always_comb begin
    if (i_num_chunks == '0)
      n_clamp = CW'(1);
    else if (i_num_chunks > CW'(max_chunks))
      n_clamp = CW'(max_chunks);
    else
      n_clamp = i_num_chunks;
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          n_d     = n_clamp;
          acc_d   = tree_ext;
          cnt_d   = CW'(1);
          state_d = (n_clamp == CW'(1)) ? HOLD : ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          acc_d = acc_q + tree_ext;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == n_q - CW'(1))
            state_d = HOLD;
        end
      end
      HOLD: begin
        if (i_ready)
          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
    end
  end

  // Narrowing only exists when the output is smaller than the accumulator.
  if (out_width < acc_width) begin : g_narrow
`ifdef VEC_SUM_SEQ_SAT_EN
    logic [acc_width-out_width:0] top;
    logic                         ovf;
    assign top = acc_q[acc_width-1:out_width-1];
    assign ovf = ~(&top) & (|top);
    assign o_sum = !ovf ? acc_q[out_width-1:0]
                 : acc_q[acc_width-1] ? {1'b1, {(out_width-1){1'b0}}}
                 : {1'b0, {(out_width-1){1'b1}}};
`else
    assign o_sum = out_width'(acc_q);
`endif
  end else begin : g_full
    assign o_sum = acc_q;
  end

endmodule

// File: tb/tb_vec_sum_seq.sv
// Directed bench for vec_sum_seq; a second narrow instance covers the
// saturate/wrap reduction of an extreme job.
module tb_vec_sum_seq;

  localparam int BW = 16;
  localparam int LN = 32;
  localparam int MC = 64;
  localparam int TW = BW + $clog2(LN);
  localparam int AW = TW + $clog2(MC);

  logic              clk = 0;
  logic              rst = 1;
  logic [BW*LN-1:0]  vec = '0;
  logic [$clog2(MC):0] nch = '0;
  logic              vld = 0;
  logic              rdy_in = 0;

  logic              o_ready, o_valid, o_busy;
  logic [AW-1:0]     o_sum;
  logic              o_ready2, o_valid2, o_busy2;
  logic [TW-1:0]     o_sum2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_sum_seq #(
    .bit_width(BW), .length(LN), .max_chunks(MC)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_vec(vec), .i_num_chunks(nch),
    .i_valid(vld), .o_ready(o_ready), .o_sum(o_sum),
    .o_valid(o_valid), .i_ready(rdy_in), .o_busy(o_busy)
  );

  vec_sum_seq #(
    .bit_width(BW), .length(LN), .max_chunks(MC), .out_width(TW)
  ) dut2 (
    .i_clk(clk), .i_rst(rst), .i_vec(vec), .i_num_chunks(nch),
    .i_valid(vld), .o_ready(o_ready2), .o_sum(o_sum2),
    .o_valid(o_valid2), .i_ready(rdy_in), .o_busy(o_busy2)
  );

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_vec(input int v);
    for (int k = 0; k < LN; k++) vec[k*BW +: BW] = BW'(v);
  endtask

  function automatic longint sum1();
    return longint'($signed(o_sum));
  endfunction

  task automatic release_out();
    vld = 0;
    rdy_in = 1;
    step();
    rdy_in = 0;
  endtask

  initial begin
    longint exp2;

    // Reset state
    step(); step();
    chk("rst_valid", o_valid, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_sum", sum1(), 0);
    rst = 0;
    step();

    // Single chunk of all 1
    set_vec(1); nch = 1; vld = 1;
    step();
    vld = 0;
    chk("single_valid", o_valid, 1);
    chk("single_sum", sum1(), 32);
    chk("single_ready", o_ready, 0);
    chk("single_busy", o_busy, 1);
    step();
    chk("single_hold", o_valid, 1);
    release_out();
    chk("single_done_valid", o_valid, 0);
    chk("single_done_ready", o_ready, 1);

    // Four chunks of -3 with idle gaps
    set_vec(-3); nch = 4;
    for (int b = 1; b <= 4; b++) begin
      vld = 1;
      step();
      vld = 0;
      if (b < 4) begin
        step(); step();
        chk("gap_valid", o_valid, 0);
        chk("gap_busy", o_busy, 1);
      end
    end
    chk("four_valid", o_valid, 1);
    chk("four_sum", sum1(), -384);

    // Backpressure with a stalled producer
    set_vec(7); nch = 1; vld = 1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("bp_sum", sum1(), -384);
      chk("bp_ready", o_ready, 0);
      chk("bp_valid", o_valid, 1);
    end
    rdy_in = 1;
    step();
    rdy_in = 0;
    chk("bp_rel_valid", o_valid, 0);
    chk("bp_rel_ready", o_ready, 1);
    step();
    vld = 0;
    chk("next_valid", o_valid, 1);
    chk("next_sum", sum1(), 224);
    release_out();

    // Clamp: zero chunks acts as one
    set_vec(5); nch = 0; vld = 1;
    step();
    vld = 0;
    chk("clamp0_valid", o_valid, 1);
    chk("clamp0_sum", sum1(), 160);
    release_out();

    // Clamp above max, extreme negative elements
    set_vec(-32768); nch = 7'(MC + 5); vld = 1;
    for (int b = 1; b < MC; b++) step();
    chk("clampmax_pre_valid", o_valid, 0);
    chk("clampmax_pre_busy", o_busy, 1);
    step();
    chk("clampmax_valid", o_valid, 1);
    chk("clampmax_sum", sum1(), -67108864);
`ifdef VEC_SUM_SEQ_SAT_EN
    exp2 = -1048576;
`else
    exp2 = 0;
`endif
    chk("narrow_sum", longint'($signed(o_sum2)), exp2);
    step();
    chk("clampmax_stall_sum", sum1(), -67108864);
    release_out();

    // Reset in the middle of a 4-chunk job
    set_vec(9); nch = 4; vld = 1;
    step(); step();
    vld = 0;
    chk("mid_busy", o_busy, 1);
    rst = 1;
    #1;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_ready", o_ready, 1);
    chk("midrst_valid", o_valid, 0);
    chk("midrst_sum", sum1(), 0);
    step();
    rst = 0;
    step();
    set_vec(2); nch = 1; vld = 1;
    step();
    vld = 0;
    chk("post_valid", o_valid, 1);
    chk("post_sum", sum1(), 64);
    release_out();
    chk("post_idle", o_busy, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
